uart_seq_checker: RTL and testbench

- Parametrised successor to the team's fixed three-byte UART scoreboard.
- Expected words are queued through a ready/valid push port into an internal FIFO of depth DEPTH.
- Each received UART word is compared against the FIFO head. Match, mismatch and underflow are counted, and a sticky error flag is kept.
- Sits in the UART verification environment between the stimulus driver (expected side) and the UART RX output (actual side).

---
 rtl/uart_chk_pkg.sv | 26 ++
 rtl/uart_chk_fifo.sv | 72 +++++++
 rtl/uart_seq_checker.sv | 172 +++++++++++++++++
 tb/tb_uart_seq_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_chk_pkg.sv
// Shared types and helpers for the UART sequence checker.
package uart_chk_pkg;

    typedef enum logic [1:0] {
        RES_NONE      = 2'd0,
        RES_MATCH     = 2'd1,
        RES_MISMATCH  = 2'd2,
        RES_UNDERFLOW = 2'd3
    } cmp_res_e;

    // Increment that sticks at 2^width-1; width is the counter width (1..32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        if (width >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (val >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/uart_chk_fifo.sv
// Expected-word FIFO for the UART checker: power-of-two storage, wrapping
// pointers, explicit occupancy counter and a synchronous flush.
module uart_chk_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full_s    = (level_r == LW'(DEPTH));
    assign empty_s   = (level_r == {LW{1'b0}});
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    // Pointers and occupancy; flush returns everything to the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Data storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign level = level_r;
    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: rtl/uart_seq_checker.sv
// UART sequence checker: compares received words against a FIFO of expected
// words. Optional first-error capture under UART_SEQ_CHECKER_FIRST_ERR_EN.
module uart_seq_checker
    import uart_chk_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       exp_valid,
    input  logic [DATA_W-1:0]          exp_data,
    output logic                       exp_ready,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic [DATA_W-1:0]          cmp_mask,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full,
    output logic                       match_pulse,
    output logic                       mismatch_pulse,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [CNT_W-1:0]           mismatch_cnt,
    output logic [CNT_W-1:0]           underflow_cnt,
`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
    output logic                       first_err_valid,
    output logic [DATA_W-1:0]          first_err_exp,
    output logic [DATA_W-1:0]          first_err_act,
    output logic [CNT_W-1:0]           first_err_idx,
`endif
    output logic                       err
);

    logic [DATA_W-1:0] head_s;
    logic              empty_s;
    logic              full_s;
    cmp_res_e          res_s;
    logic              match_pulse_r;
    logic              mismatch_pulse_r;
    logic [CNT_W-1:0]  match_cnt_r;
    logic [CNT_W-1:0]  mismatch_cnt_r;
    logic [CNT_W-1:0]  underflow_cnt_r;
    logic              err_r;

    uart_chk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear),
        .push      (exp_valid && !clear),
        .push_data (exp_data),
        .pop       (rx_valid && !clear),
        .head      (head_s),
        .level     (level),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Classify the received word against the FIFO head.
    always_comb begin
        res_s = RES_NONE;
        if (!rx_valid) begin
            res_s = RES_NONE;
        end else if (empty_s) begin
            res_s = RES_UNDERFLOW;
        end else if (((rx_data ^ head_s) & cmp_mask) == {DATA_W{1'b0}}) begin
            res_s = RES_MATCH;
        end else begin
            res_s = RES_MISMATCH;
        end
    end

    // Event counters, pulses and sticky error; clear overrides this cycle's event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_pulse_r    <= 1'b0;
            mismatch_pulse_r <= 1'b0;
            match_cnt_r      <= {CNT_W{1'b0}};
            mismatch_cnt_r   <= {CNT_W{1'b0}};
            underflow_cnt_r  <= {CNT_W{1'b0}};
            err_r            <= 1'b0;
        end else if (clear) begin
            match_pulse_r    <= 1'b0;
            mismatch_pulse_r <= 1'b0;
            match_cnt_r      <= {CNT_W{1'b0}};
            mismatch_cnt_r   <= {CNT_W{1'b0}};
            underflow_cnt_r  <= {CNT_W{1'b0}};
            err_r            <= 1'b0;
        end else begin
            match_pulse_r    <= 1'b0;
            mismatch_pulse_r <= 1'b0;
            case (res_s)
                RES_MATCH: begin
                    match_cnt_r   <= CNT_W'(sat_inc(32'(match_cnt_r), CNT_W));
                    match_pulse_r <= 1'b1;
                end
                RES_MISMATCH: begin
                    mismatch_cnt_r   <= CNT_W'(sat_inc(32'(mismatch_cnt_r), CNT_W));
                    mismatch_pulse_r <= 1'b1;
                    err_r            <= 1'b1;
                end
                RES_UNDERFLOW: begin
                    underflow_cnt_r  <= CNT_W'(sat_inc(32'(underflow_cnt_r), CNT_W));
                    mismatch_pulse_r <= 1'b1;
                    err_r            <= 1'b1;
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
    logic              fe_valid_r;
    logic [DATA_W-1:0] fe_exp_r;
    logic [DATA_W-1:0] fe_act_r;
    logic [CNT_W-1:0]  fe_idx_r;
    logic [CNT_W+1:0]  total_sum_s;
    logic [CNT_W-1:0]  total_s;

    // Words seen so far, clamped to the counter range.
    always_comb begin
        total_sum_s = {2'b00, match_cnt_r} + {2'b00, mismatch_cnt_r} + {2'b00, underflow_cnt_r};
        if (total_sum_s[CNT_W+1:CNT_W] != 2'b00) begin
            total_s = {CNT_W{1'b1}};
        end else begin
            total_s = total_sum_s[CNT_W-1:0];
        end
    end

    // Capture the first failing compare after reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_valid_r <= 1'b0;
            fe_exp_r   <= {DATA_W{1'b0}};
            fe_act_r   <= {DATA_W{1'b0}};
            fe_idx_r   <= {CNT_W{1'b0}};
        end else if (clear) begin
            fe_valid_r <= 1'b0;
            fe_exp_r   <= {DATA_W{1'b0}};
            fe_act_r   <= {DATA_W{1'b0}};
            fe_idx_r   <= {CNT_W{1'b0}};
        end else if (!fe_valid_r && (res_s == RES_MISMATCH || res_s == RES_UNDERFLOW)) begin
            fe_valid_r <= 1'b1;
            fe_exp_r   <= (res_s == RES_MISMATCH) ? head_s : {DATA_W{1'b0}};
            fe_act_r   <= rx_data;
            fe_idx_r   <= total_s;
        end
    end

    assign first_err_valid = fe_valid_r;
    assign first_err_exp   = fe_exp_r;
    assign first_err_act   = fe_act_r;
    assign first_err_idx   = fe_idx_r;
`endif

    assign exp_ready      = !full_s;
    assign empty          = empty_s;
    assign full           = full_s;
    assign match_pulse    = match_pulse_r;
    assign mismatch_pulse = mismatch_pulse_r;
    assign match_cnt      = match_cnt_r;
    assign mismatch_cnt   = mismatch_cnt_r;
    assign underflow_cnt  = underflow_cnt_r;
    assign err            = err_r;

endmodule

// File: tb/tb_uart_seq_checker.sv
// Directed bench for uart_seq_checker: a default instance and a small
// DEPTH=4 / CNT_W=4 instance share the same stimulus.
module tb_uart_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] cmp_mask;

    logic       d_exp_ready, d_empty, d_full, d_match_pulse, d_mismatch_pulse, d_err;
    logic [4:0] d_level;
    logic [15:0] d_match_cnt, d_mismatch_cnt, d_underflow_cnt;

    logic       s_exp_ready, s_empty, s_full, s_match_pulse, s_mismatch_pulse, s_err;
    logic [2:0] s_level;
    logic [3:0] s_match_cnt, s_mismatch_cnt, s_underflow_cnt;

`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
    logic        d_fe_valid, s_fe_valid;
    logic [7:0]  d_fe_exp, d_fe_act, s_fe_exp, s_fe_act;
    logic [15:0] d_fe_idx;
    logic [3:0]  s_fe_idx;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_seq_checker u_dut (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .exp_valid (exp_valid), .exp_data (exp_data), .exp_ready (d_exp_ready),
        .rx_valid (rx_valid), .rx_data (rx_data), .cmp_mask (cmp_mask),
        .level (d_level), .empty (d_empty), .full (d_full),
        .match_pulse (d_match_pulse), .mismatch_pulse (d_mismatch_pulse),
        .match_cnt (d_match_cnt), .mismatch_cnt (d_mismatch_cnt), .underflow_cnt (d_underflow_cnt),
`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
        .first_err_valid (d_fe_valid), .first_err_exp (d_fe_exp),
        .first_err_act (d_fe_act), .first_err_idx (d_fe_idx),
`endif
        .err (d_err)
    );

    uart_seq_checker #(.DATA_W (8), .DEPTH (4), .CNT_W (4)) u_small (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .exp_valid (exp_valid), .exp_data (exp_data), .exp_ready (s_exp_ready),
        .rx_valid (rx_valid), .rx_data (rx_data), .cmp_mask (cmp_mask),
        .level (s_level), .empty (s_empty), .full (s_full),
        .match_pulse (s_match_pulse), .mismatch_pulse (s_mismatch_pulse),
        .match_cnt (s_match_cnt), .mismatch_cnt (s_mismatch_cnt), .underflow_cnt (s_underflow_cnt),
`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
        .first_err_valid (s_fe_valid), .first_err_exp (s_fe_exp),
        .first_err_act (s_fe_act), .first_err_idx (s_fe_idx),
`endif
        .err (s_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; exp_valid = 1'b0; exp_data = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; cmp_mask = 8'hFF;
        tick(); tick();
        check("rst_level", 32'(d_level), 32'd0);
        check("rst_empty", 32'(d_empty), 32'd1);
        check("rst_full", 32'(d_full), 32'd0);
        check("rst_ready", 32'(d_exp_ready), 32'd1);
        check("rst_match_cnt", 32'(d_match_cnt), 32'd0);
        check("rst_mismatch_cnt", 32'(d_mismatch_cnt), 32'd0);
        check("rst_underflow_cnt", 32'(d_underflow_cnt), 32'd0);
        check("rst_err", 32'(d_err), 32'd0);
        check("rst_pulses", 32'({d_match_pulse, d_mismatch_pulse}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Three in-order matches
        exp_valid = 1'b1;
        exp_data = 8'h41; tick();
        exp_data = 8'h42; tick();
        exp_data = 8'h43; tick();
        exp_valid = 1'b0;
        check("t1_level3", 32'(d_level), 32'd3);
        rx_valid = 1'b1;
        rx_data = 8'h41; tick(); check("t1_pulse_a", 32'(d_match_pulse), 32'd1);
        rx_data = 8'h42; tick(); check("t1_pulse_b", 32'(d_match_pulse), 32'd1);
        rx_data = 8'h43; tick(); check("t1_pulse_c", 32'(d_match_pulse), 32'd1);
        rx_valid = 1'b0;
        tick();
        check("t1_pulse_off", 32'(d_match_pulse), 32'd0);
        check("t1_match_cnt", 32'(d_match_cnt), 32'd3);
        check("t1_mismatch_cnt", 32'(d_mismatch_cnt), 32'd0);
        check("t1_err", 32'(d_err), 32'd0);
        check("t1_level0", 32'(d_level), 32'd0);

        // Mismatch
        do_clear();
        exp_valid = 1'b1; exp_data = 8'h41; tick();
        exp_valid = 1'b0; rx_valid = 1'b1; rx_data = 8'h58; tick();
        rx_valid = 1'b0;
        check("t2_mm_pulse", 32'(d_mismatch_pulse), 32'd1);
        check("t2_mismatch_cnt", 32'(d_mismatch_cnt), 32'd1);
        check("t2_match_cnt", 32'(d_match_cnt), 32'd0);
        check("t2_err", 32'(d_err), 32'd1);
        check("t2_level", 32'(d_level), 32'd0);
`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
        check("t2_fe_valid", 32'(d_fe_valid), 32'd1);
        check("t2_fe_exp", 32'(d_fe_exp), 32'h41);
        check("t2_fe_act", 32'(d_fe_act), 32'h58);
        check("t2_fe_idx", 32'(d_fe_idx), 32'd0);
`endif
        tick();
        check("t2_mm_pulse_off", 32'(d_mismatch_pulse), 32'd0);
        check("t2_err_sticky", 32'(d_err), 32'd1);

        // Masked compare ignores bit 7
        do_clear();
        exp_valid = 1'b1; exp_data = 8'h41; tick();
        exp_valid = 1'b0; cmp_mask = 8'h7F; rx_valid = 1'b1; rx_data = 8'hC1; tick();
        rx_valid = 1'b0; cmp_mask = 8'hFF;
        check("t3_match_cnt", 32'(d_match_cnt), 32'd1);
        check("t3_mismatch_cnt", 32'(d_mismatch_cnt), 32'd0);
        check("t3_err", 32'(d_err), 32'd0);

        // Underflow with simultaneous push: no bypass
        do_clear();
        exp_valid = 1'b1; exp_data = 8'h10; rx_valid = 1'b1; rx_data = 8'h10; tick();
        exp_valid = 1'b0; rx_valid = 1'b0;
        check("t4_underflow_cnt", 32'(d_underflow_cnt), 32'd1);
        check("t4_err", 32'(d_err), 32'd1);
        check("t4_level", 32'(d_level), 32'd1);
        check("t4_mm_pulse", 32'(d_mismatch_pulse), 32'd1);
        check("t4_match_cnt0", 32'(d_match_cnt), 32'd0);
`ifdef UART_SEQ_CHECKER_FIRST_ERR_EN
        check("t4_fe_exp", 32'(d_fe_exp), 32'h00);
        check("t4_fe_act", 32'(d_fe_act), 32'h10);
`endif
        rx_valid = 1'b1; rx_data = 8'h10; tick();
        rx_valid = 1'b0;
        check("t4_match_cnt1", 32'(d_match_cnt), 32'd1);
        check("t4_level0", 32'(d_level), 32'd0);
        check("t4_match_pulse", 32'(d_match_pulse), 32'd1);

        // Fill DEPTH=4 instance; fifth word is dropped
        do_clear();
        exp_valid = 1'b1;
        exp_data = 8'hA0; tick();
        exp_data = 8'hA1; tick();
        exp_data = 8'hA2; tick();
        exp_data = 8'hA3; tick();
        check("t5_s_level4", 32'(s_level), 32'd4);
        check("t5_s_full", 32'(s_full), 32'd1);
        check("t5_s_ready0", 32'(s_exp_ready), 32'd0);
        exp_data = 8'hA4; tick();
        exp_valid = 1'b0;
        check("t5_s_level_hold", 32'(s_level), 32'd4);
        check("t5_d_level5", 32'(d_level), 32'd5);
        rx_valid = 1'b1;
        rx_data = 8'hA0; tick();
        check("t5_s_level3", 32'(s_level), 32'd3);
        check("t5_s_ready1", 32'(s_exp_ready), 32'd1);
        check("t5_s_full0", 32'(s_full), 32'd0);
        rx_data = 8'hA1; tick();
        rx_data = 8'hA2; tick();
        rx_data = 8'hA3; tick();
        rx_data = 8'hA4; tick();
        rx_valid = 1'b0;
        check("t5_s_match_cnt", 32'(s_match_cnt), 32'd4);
        check("t5_s_underflow", 32'(s_underflow_cnt), 32'd1);
        check("t5_s_err", 32'(s_err), 32'd1);
        check("t5_d_match_cnt", 32'(d_match_cnt), 32'd5);
        check("t5_d_underflow", 32'(d_underflow_cnt), 32'd0);

        // Counter saturation, then clear beats a concurrent rx/push
        do_clear();
        exp_valid = 1'b1; exp_data = 8'h55; tick();
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (17) tick();
        exp_valid = 1'b0; rx_valid = 1'b0;
        check("t6_s_match_sat", 32'(s_match_cnt), 32'd15);
        check("t6_d_match_cnt", 32'(d_match_cnt), 32'd17);
        check("t6_s_level", 32'(s_level), 32'd1);
        clear = 1'b1; rx_valid = 1'b1; exp_valid = 1'b1; tick();
        clear = 1'b0; rx_valid = 1'b0; exp_valid = 1'b0;
        check("t6_clr_s_match", 32'(s_match_cnt), 32'd0);
        check("t6_clr_s_level", 32'(s_level), 32'd0);
        check("t6_clr_d_match", 32'(d_match_cnt), 32'd0);
        check("t6_clr_d_level", 32'(d_level), 32'd0);
        check("t6_clr_d_err", 32'(d_err), 32'd0);
        check("t6_clr_pulse", 32'(d_match_pulse), 32'd0);
        tick();
        check("t6_post_match", 32'(d_match_cnt), 32'd0);
        check("t6_post_underflow", 32'(d_underflow_cnt), 32'd0);

        // Asynchronous reset mid-operation
        exp_valid = 1'b1; exp_data = 8'h77; tick();
        exp_valid = 1'b0;
        check("t7_level1", 32'(d_level), 32'd1);
        rx_valid = 1'b1; rx_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_level", 32'(d_level), 32'd0);
        check("t7_async_empty", 32'(d_empty), 32'd1);
        tick();
        rx_valid = 1'b0;
        check("t7_mismatch_cnt", 32'(d_mismatch_cnt), 32'd0);
        check("t7_err", 32'(d_err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t7_post_mismatch", 32'(d_mismatch_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
